// File: rtl/tty_in.sv
// rtl/tty_in.sv - memory-mapped console receive FIFO with CPU register access and level irq
// Optional TTY_IN_OVERFLOW_EN: never back-pressure, drop on full and latch sticky ovf.
module tty_in #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data,
    input  logic [1:0]  reg_sel,
    output logic [31:0] out,
    input  logic        rd,
    input  logic        wr,
    input  logic        en,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        irq
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        irq_en_q, irq_en_d;
    logic [15:0] thresh_q, thresh_d;
    logic        ovf;

    logic [AW:0] count;
    logic [15:0] count16;
    logic [15:0] thresh_eff;
    logic        empty, full;
    logic        push, pop, flush, ctrl_wr;
    logic [31:0] rd_data;
    logic        unused_data;

    assign count   = wr_ptr_q - rd_ptr_q;
    assign count16 = 16'(count);
    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);

    assign pop     = rd && en && (reg_sel == 2'd0) && !empty;
    assign flush   = wr && en && (reg_sel == 2'd3) && data[0];
    assign ctrl_wr = wr && en && (reg_sel == 2'd2);
    assign unused_data = ^data[15:1];

`ifdef TTY_IN_OVERFLOW_EN
    logic ovf_q, ovf_d;
    logic clr_ovf;

    assign clr_ovf  = wr && en && (reg_sel == 2'd3) && data[1];
    assign in_ready = 1'b1;
    assign push     = in_valid && !flush && (!full || pop);
    assign ovf      = ovf_q;

    // A drop in the same cycle as a clear re-arms ovf, so no loss goes unreported.
    always_comb begin
        ovf_d = ovf_q;
        if (clr_ovf)
            ovf_d = 1'b0;
        if (in_valid && full && !pop && !flush)
            ovf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf_q <= 1'b0;
        else
            ovf_q <= ovf_d;
    end
`else
    assign in_ready = !full && !flush;
    assign push     = in_valid && in_ready;
    assign ovf      = 1'b0;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push)
                wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_comb begin
        irq_en_d = irq_en_q;
        thresh_d = thresh_q;
        if (ctrl_wr) begin
            irq_en_d = data[0];
            thresh_d = data[31:16];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            irq_en_q <= 1'b0;
            thresh_q <= 16'd1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            irq_en_q <= irq_en_d;
            thresh_q <= thresh_d;
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q[AW-1:0]] <= in_data;
    end

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            2'd0: rd_data = empty ? 32'h0 : {1'b1, 23'b0, mem_q[rd_ptr_q[AW-1:0]]};
            2'd1: rd_data = {count16, 13'b0, ovf, full, empty};
            2'd2: rd_data = {thresh_q, 15'b0, irq_en_q};
            default: rd_data = '0;
        endcase
    end

    assign out = (rd && en) ? rd_data : 'z;

    assign thresh_eff = (thresh_q == 16'd0) ? 16'd1 : thresh_q;
    assign irq        = irq_en_q && (count16 >= thresh_eff);

endmodule

// File: tb/tb_tty_in.sv
// tb/tb_tty_in.sv - scoreboard bench for tty_in
module tb_tty_in;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data;
    logic [1:0]  reg_sel;
    wire  [31:0] out;
    logic        rd, wr, en;
    logic [7:0]  in_data;
    logic        in_valid;
    wire         in_ready;
    wire         irq;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    logic [31:0] v;

    tty_in #(.DEPTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .data     (data),
        .reg_sel  (reg_sel),
        .out      (out),
        .rd       (rd),
        .wr       (wr),
        .en       (en),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        rd = 1'b0; wr = 1'b0; en = 1'b0; reg_sel = 2'd0; data = 32'h0;
    endtask

    task automatic bus_read(input logic [1:0] sel, output logic [31:0] val);
        @(negedge clk);
        rd = 1'b1; en = 1'b1; reg_sel = sel;
        #1 val = out;
        @(posedge clk);
        #1 bus_idle();
    endtask

    task automatic bus_write(input logic [1:0] sel, input logic [31:0] val);
        @(negedge clk);
        wr = 1'b1; en = 1'b1; reg_sel = sel; data = val;
        @(posedge clk);
        #1 bus_idle();
    endtask

    task automatic check_status(input string tag, input logic [31:0] exp);
        logic [31:0] s;
        bus_read(2'd1, s);
        check_eq(tag, s, exp);
    endtask

    task automatic read_data(input string tag);
        logic [31:0] exp;
        logic [31:0] got;
        exp = (exp_q.size() != 0) ? {1'b1, 23'b0, exp_q[0]} : 32'h0;
        @(negedge clk);
        rd = 1'b1; en = 1'b1; reg_sel = 2'd0;
        #1 got = out;
        check_eq(tag, got, exp);
        @(posedge clk);
        if (exp_q.size() != 0)
            void'(exp_q.pop_front());
        #1 bus_idle();
    endtask

    task automatic push_byte(input logic [7:0] b);
        logic ok;
        ok = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_data = b;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (in_ready) begin
                ok = 1'b1;
                @(posedge clk);
                break;
            end
            @(negedge clk);
        end
        #1 in_valid = 1'b0;
        if (ok)
            exp_q.push_back(b);
        else
            check_eq("push_timeout", 32'(ok), 32'h1);
    endtask

    task automatic drain(input string tag);
        int n;
        n = exp_q.size();
        for (int i = 0; i < n; i++)
            read_data(tag);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h0;
        bus_idle();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        check_eq("rst_out_idle", 32'((out === 32'hz) || (out === 32'h0)), 32'h1);
        check_eq("rst_irq", 32'(irq), 32'h0);
        check_eq("rst_in_ready", 32'(in_ready), 32'h1);
        check_status("rst_status", 32'h0000_0001);
        read_data("rst_data");
        bus_read(2'd2, v);
        check_eq("rst_ctrl", v, 32'h0001_0000);

        push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
        read_data("abc_0"); read_data("abc_1"); read_data("abc_2");
        check_status("abc_status", 32'h0000_0001);

        for (int i = 0; i < 16; i++)
            push_byte(8'(8'h10 + i));
        check_status("full_status", 32'h0010_0002);
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h99;
`ifdef TTY_IN_OVERFLOW_EN
        #1 check_eq("full_ready", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        check_status("ovf_status", 32'h0010_0006);
        bus_write(2'd3, 32'h2);
        check_status("ovf_clear", 32'h0010_0002);
`else
        #1 check_eq("full_ready", 32'(in_ready), 32'h0);
        read_data("full_pop");
        @(negedge clk);
        #1 check_eq("held_ready", 32'(in_ready), 32'h1);
        @(posedge clk);
        exp_q.push_back(8'h99);
        #1 in_valid = 1'b0;
        check_status("refill_status", 32'h0010_0002);
`endif
        drain("full_drain");
        check_status("full_empty", 32'h0000_0001);

        bus_write(2'd2, 32'h0003_0001);
        bus_read(2'd2, v);
        check_eq("ctrl_rb", v, 32'h0003_0001);
        push_byte(8'h61); push_byte(8'h62);
        check_eq("irq_below", 32'(irq), 32'h0);
        push_byte(8'h63);
        check_eq("irq_at", 32'(irq), 32'h1);
        read_data("irq_pop");
        check_eq("irq_after_pop", 32'(irq), 32'h0);
        drain("irq_drain");
        bus_write(2'd2, 32'h0000_0001);
        push_byte(8'h64);
        check_eq("irq_thresh0", 32'(irq), 32'h1);
        drain("thresh0_drain");
        bus_write(2'd2, 32'h0001_0000);

        for (int i = 0; i < 5; i++)
            push_byte(8'(8'h70 + i));
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h7f;
        rd = 1'b1; en = 1'b1; reg_sel = 2'd0;
        #1 check_eq("pp_head", out, {1'b1, 23'b0, exp_q[0]});
        @(posedge clk);
        void'(exp_q.pop_front());
        exp_q.push_back(8'h7f);
        #1 in_valid = 1'b0;
        bus_idle();
        check_status("pp_count", 32'h0005_0000);
        drain("pp_drain");

        for (int i = 0; i < 40; i++) begin
            push_byte(8'($urandom_range(0, 255)));
            if (exp_q.size() >= 10)
                read_data("wrap");
        end
        drain("wrap_drain");
        check_status("wrap_empty", 32'h0000_0001);

        for (int i = 0; i < 8; i++)
            push_byte(8'(8'hc0 + i));
        @(negedge clk);
        wr = 1'b1; en = 1'b1; reg_sel = 2'd3; data = 32'h1;
        in_valid = 1'b1; in_data = 8'hee;
`ifdef TTY_IN_OVERFLOW_EN
        #1 check_eq("flush_ready", 32'(in_ready), 32'h1);
`else
        #1 check_eq("flush_ready", 32'(in_ready), 32'h0);
`endif
        @(posedge clk);
        exp_q.delete();
        #1 in_valid = 1'b0;
        bus_idle();
        check_status("flush_status", 32'h0000_0001);
        read_data("flush_data");

        push_byte(8'h31); push_byte(8'h32); push_byte(8'h33);
        bus_write(2'd2, 32'h0005_0001);
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h34;
        #2 rst = 1'b1;
        #1 check_eq("rst_mid_ready", 32'(in_ready), 32'h1);
        check_eq("rst_mid_irq", 32'(irq), 32'h0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        #2 rst = 1'b0;
        exp_q.delete();
        check_eq("rst2_out_idle", 32'((out === 32'hz) || (out === 32'h0)), 32'h1);
        check_status("rst2_status", 32'h0000_0001);
        bus_read(2'd2, v);
        check_eq("rst2_ctrl", v, 32'h0001_0000);
        read_data("rst2_data");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
